// File: rtl/traffic_pkg.sv
// Light encodings, controller state enum and small helpers shared by the traffic controllers.
// WALK is present only when INTERSECTION_SCHEDULER_PED_EN is defined.
package traffic_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] GREEN  = 2'b01;
  localparam logic [1:0] YELLOW = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GREEN,
    ST_YELLOW,
    ST_ALLRED
`ifdef INTERSECTION_SCHEDULER_PED_EN
    ,
    ST_WALK
`endif
  } state_t;

  // Place one 2-bit colour on approach idx; every other approach stays red.
  function automatic logic [7:0] lamp(input logic [1:0] idx, input logic [1:0] color);
    lamp = 8'(color) << {idx, 1'b0};
  endfunction

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    umax = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick: first requester after last, wrapping back to last.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    valid = |req;
    idx   = last;
    cand  = last;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/intersection_scheduler.sv
// Four-approach intersection scheduler with round-robin service and timed phases.
// Define INTERSECTION_SCHEDULER_PED_EN to add the pedestrian button and WALK phase.
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned MAX_GREEN = 10,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned WALK_T    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] req,
`ifdef INTERSECTION_SCHEDULER_PED_EN
  input  logic       ped_req,
`endif
  output logic [7:0] light,
  output logic [1:0] grant,
  output logic       walk
);

  localparam int unsigned TMAX = umax(umax(MAX_GREEN, MIN_GREEN), umax(umax(YELLOW_T, ALLRED_T), WALK_T));
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned EW   = TW + 1;

  state_t        state;
  logic [TW-1:0] timer;
  logic [EW-1:0] elapsed;
  logic          rr_valid;
  logic [1:0]    rr_idx;
  logic          ped_any;
  logic          contest;

  rr_arbiter4 u_rr (
    .req   (req),
    .last  (grant),
    .valid (rr_valid),
    .idx   (rr_idx)
  );

`ifdef INTERSECTION_SCHEDULER_PED_EN
  logic pend;
  assign ped_any = pend | ped_req;
`else
  assign ped_any = 1'b0;
`endif

  // elapsed counts the tick arriving this cycle, so a phase of N ticks ends when elapsed >= N.
  always_comb begin
    elapsed = {1'b0, timer} + EW'(1);
    contest = (|(req & ~(4'(1) << grant))) | ped_any;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      timer <= '0;
      grant <= 2'd3;
      light <= 8'h00;
      walk  <= 1'b0;
`ifdef INTERSECTION_SCHEDULER_PED_EN
      pend  <= 1'b0;
`endif
    end else begin
`ifdef INTERSECTION_SCHEDULER_PED_EN
      if (ped_req) pend <= 1'b1;
`endif
      if (tick && (timer != TW'(MAX_GREEN))) timer <= timer + TW'(1);

      case (state)
        ST_IDLE: begin
          if (rr_valid) begin
            state <= ST_GREEN;
            timer <= '0;
            grant <= rr_idx;
            light <= lamp(rr_idx, GREEN);
          end
`ifdef INTERSECTION_SCHEDULER_PED_EN
          else if (ped_any) begin
            state <= ST_ALLRED;
            timer <= '0;
          end
`endif
        end

        ST_GREEN: begin
          if (tick && (elapsed >= EW'(MIN_GREEN)) && contest) begin
            state <= ST_YELLOW;
            timer <= '0;
            light <= lamp(grant, YELLOW);
          end
        end

        ST_YELLOW: begin
          if (tick && (elapsed >= EW'(YELLOW_T))) begin
            state <= ST_ALLRED;
            timer <= '0;
            light <= 8'h00;
          end
        end

        ST_ALLRED: begin
          if (tick && (elapsed >= EW'(ALLRED_T))) begin
            timer <= '0;
`ifdef INTERSECTION_SCHEDULER_PED_EN
            if (ped_any) begin
              state <= ST_WALK;
              walk  <= 1'b1;
              pend  <= 1'b0;
            end else
`endif
            if (rr_valid) begin
              state <= ST_GREEN;
              grant <= rr_idx;
              light <= lamp(rr_idx, GREEN);
            end else begin
              state <= ST_IDLE;
            end
          end
        end

`ifdef INTERSECTION_SCHEDULER_PED_EN
        ST_WALK: begin
          if (tick && (elapsed >= EW'(WALK_T))) begin
            timer <= '0;
            walk  <= 1'b0;
            if (rr_valid) begin
              state <= ST_GREEN;
              grant <= rr_idx;
              light <= lamp(rr_idx, GREEN);
            end else begin
              state <= ST_IDLE;
            end
          end
        end
`endif

        default: begin
          state <= ST_IDLE;
          timer <= '0;
          light <= 8'h00;
          walk  <= 1'b0;
        end
      endcase
    end
  end

endmodule
